// File: rtl/gcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gcd_scheduler
// Purpose  : Round-robin front end that shares one GCD engine among N_REQ
//            requesters, handshaking with the engine through start/done.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_scheduler #(
   parameter int N_REQ = 4,
   parameter int W     = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ*W-1:0]   req_a,
   input  logic [N_REQ*W-1:0]   req_b,
   output logic [N_REQ-1:0]     gnt,
   output logic                 rsp_valid,
   output logic [2:0]           rsp_id,
   output logic [2*W-1:0]       rsp_data,
   output logic                 eng_start,
   output logic [W-1:0]         eng_a,
   output logic [W-1:0]         eng_b,
   input  logic [2*W-1:0]       eng_result,
   input  logic                 eng_done,
   output logic                 busy,
   output logic [15:0]          op_count
);

   typedef enum logic [2:0] {
      S_SYNC    = 3'd0,
      S_IDLE    = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t             r_state;
   logic [2:0]         r_last;
   logic [2:0]         r_cur;

   logic               w_any;
   logic [2:0]         w_win;
   logic [4:0]         w_idx;
   logic [N_REQ-1:0]   w_req_sh;
   logic [N_REQ-1:0]   w_onehot;
   logic [N_REQ*W-1:0] w_sha;
   logic [N_REQ*W-1:0] w_shb;

   // Round-robin search: scan from the slot after the previous winner.
   always_comb begin
      w_any    = 1'b0;
      w_win    = '0;
      w_idx    = '0;
      w_req_sh = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = 5'(r_last) + 5'd1 + 5'(k);
         if (w_idx >= 5'(N_REQ)) w_idx = w_idx - 5'(N_REQ);
         w_req_sh = req >> w_idx;
         if (!w_any && w_req_sh[0]) begin
            w_any = 1'b1;
            w_win = w_idx[2:0];
         end
      end
   end

   assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
   assign w_sha    = req_a >> (32'(w_win) * W);
   assign w_shb    = req_b >> (32'(w_win) * W);
   assign busy     = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_SYNC;
         r_last    <= 3'(N_REQ - 1);
         r_cur     <= '0;
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         eng_start <= 1'b0;
         eng_a     <= '0;
         eng_b     <= '0;
         op_count  <= '0;
      end else begin
         gnt       <= '0;
         rsp_valid <= 1'b0;
         case (r_state)
            S_SYNC: begin
               eng_start <= 1'b0;
               if (eng_done) r_state <= S_IDLE;
            end
            S_IDLE: begin
               if (w_any) begin
                  gnt       <= w_onehot;
                  eng_a     <= w_sha[W-1:0];
                  eng_b     <= w_shb[W-1:0];
                  r_cur     <= w_win;
                  r_last    <= w_win;
                  eng_start <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            // Engine acknowledges start by dropping done; only then wait for completion.
            S_ISSUE: begin
               if (!eng_done) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (eng_done) begin
                  eng_start <= 1'b0;
                  r_state   <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               rsp_data  <= eng_result;
               rsp_id    <= r_cur;
               rsp_valid <= 1'b1;
               op_count  <= op_count + 16'd1;
               r_state   <= S_RELEASE;
            end
            S_RELEASE: begin
               r_state <= S_IDLE;
            end
            default: begin
               eng_start <= 1'b0;
               r_state   <= S_SYNC;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
